inst_fetch: RTL

- Instruction-fetch stage of the simple CPU; the initiator side of the instruction ROM interface.
- Owns the program counter and drives the word address to the ROM, which returns data combinationally in the same cycle.
- Registers the returned instruction and its PC into the IF/ID pipeline register.
- Handles stall, branch/jump redirect with flush, and a halt instruction.

---
 rtl/inst_fetch.sv | 88 ++++++++
 1 files changed

// File: rtl/inst_fetch.sv
// Instruction-fetch stage: owns the PC, addresses the combinational instruction ROM
// and fills the IF/ID pipeline register, with stall, redirect/flush and halt handling.
module inst_fetch #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int          ADDR_W    = 10,
  parameter logic [31:0] HALT_INST = 32'hFFFF_FFFF
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] rom_addr,
  input  logic [31:0]       rom_rdata,
  input  logic              stall,
  input  logic              redirect,
  input  logic [31:0]       redirect_pc,
  output logic [31:0]       pc,
  output logic [31:0]       if_inst,
  output logic [31:0]       if_pc,
  output logic              if_valid,
  output logic              halted,
  output logic              misalign
);

  typedef enum logic [1:0] {
    BOOT,
    RUN,
    HALT
  } state_t;

  state_t      state;
  logic [31:0] redirect_tgt;
  logic        redirect_bad;

  // The ROM sees the word index of the PC only; high PC bits beyond the ROM simply wrap.
  assign rom_addr     = pc[ADDR_W+1:2];
  assign redirect_tgt = {redirect_pc[31:2], 2'b00};
  assign redirect_bad = |redirect_pc[1:0];

  // NOTE: all state lives in one clocked block with non-blocking assignments, so every
  // branch reads the pre-edge values and unassigned registers simply hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= BOOT;
      pc       <= RESET_PC;
      if_inst  <= 32'h0;
      if_pc    <= 32'h0;
      if_valid <= 1'b0;
      halted   <= 1'b0;
      misalign <= 1'b0;
    end else begin
      case (state)
        // One idle cycle so the ROM output for RESET_PC is settled before first capture.
        BOOT: state <= RUN;

        RUN: begin
          if (redirect) begin
            pc       <= redirect_tgt;
            if_valid <= 1'b0;
            if (redirect_bad) misalign <= 1'b1;
          end else if (!stall) begin
            if_inst  <= rom_rdata;
            if_pc    <= pc;
            if_valid <= 1'b1;
            if (rom_rdata == HALT_INST) begin
              state  <= HALT;
              halted <= 1'b1;
            end else begin
              pc <= pc + 32'd4;
            end
          end
        end

        // Only a redirect restarts fetch; the halt word itself already went downstream.
        HALT: begin
          if_valid <= 1'b0;
          if (redirect) begin
            pc     <= redirect_tgt;
            halted <= 1'b0;
            state  <= RUN;
            if (redirect_bad) misalign <= 1'b1;
          end
        end

        default: state <= BOOT;
      endcase
    end
  end

endmodule
